tile_collision_checker: RTL
===========================

Name: tile_collision_checker

Overview:
- Answers collision queries from the player-motion block.
- Per request: takes the candidate next player position (pixel centre plus half-size) and computes the four hitbox corner tiles.
- Reads each corner tile type from the level tile-map RAM over a 1-cycle-latency read port.
- Returns a registered coll_next flag that the motion block samples on its next frame_clk edge.
- Runs on the fast system clock; one full check completes well within one frame.

Parameters:
- MAP_W, 20, tile-map width in tiles
- MAP_H, 15, tile-map height in tiles
- TILE_SHIFT, 5, log2 of tile size in pixels (32 px tiles)
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- ADDR_W, 9, tile-map address width (covers MAP_W*MAP_H = 300)
- TILE_W, 4, tile-type width

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req  in  1  one-cycle query strobe
- pos_x  in  10  candidate centre X in pixels
- pos_y  in  10  candidate centre Y in pixels
- size  in  10  hitbox half-size in pixels
- map_addr  out  ADDR_W  tile-map read address
- map_data  in  TILE_W  tile type; valid the cycle after map_addr
- busy  out  1  high from the cycle after req acceptance through DONE
- done  out  1  one-cycle pulse when coll_next is updated
- coll_next  out  1  1 = candidate position collides

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE
  - busy = 0, done = 0, map_addr = 0
  - coll_next = 1 (conservative: motion is blocked until the first completed check)
- Reset mid-operation aborts the check; the partial result is discarded.
- FSM states: IDLE, CALC, READ, DRAIN, DONE.
- IDLE:
  - req = 1 at edge k latches pos_x, pos_y and size; next state is CALC.
  - req is ignored in every other state; there is no queueing.
- CALC (cycle k+1):
  - x0 = pos_x - size
  - x1 = pos_x + size - 1
  - y0 = pos_y - size
  - y1 = pos_y + size - 1
  - All four are computed 11 bits wide so underflow and overflow are detectable.
  - A corner is out of bounds (oob) if its coordinate underflows or is >= SCREEN_W / SCREEN_H.
  - Tile column = coordinate >> TILE_SHIFT; tile row likewise.
  - Corners are registered; the collision accumulator is cleared; next state is READ.
- READ (cycles k+2..k+5, 2-bit index 0..3):
  - Corner order: (x0,y0), (x1,y0), (x0,y1), (x1,y1).
  - map_addr = row*MAP_W + col, implemented as (row<<4)+(row<<2)+col for MAP_W = 20.
  - An oob corner drives map_addr = 0 and contributes a collision regardless of map_data.
  - Starting at k+3, map_data for the previous index is ORed into the accumulator as (map_data != TILE_EMPTY).
  - After index 3, next state is DRAIN.
- DRAIN (k+6): captures the data for index 3.
- DONE (k+7):
  - coll_next <= accumulator
  - done = 1 for this cycle only
  - next state is IDLE
- Latency is fixed at 7 cycles from the req edge to done.
- busy = 1 in CALC, READ, DRAIN and DONE.
- coll_next holds its value between done pulses, so the frame_clk-domain sampler always sees a stable level.
- Duplicate corner tiles are read twice; no deduplication.

Decomposition:
- Shared package tile_pkg:
  - MAP_W, MAP_H, TILE_SHIFT
  - TILE_EMPTY = 4'h0
  - typedef tile_t (logic [3:0])
  - typedef map_addr_t (logic [8:0])
  - checker state enum
- Sub-module tile_addr_calc: combinational block that takes one corner (11-bit x, 11-bit y) and returns map_addr_t plus the oob flag. It is instantiated once and muxed by the READ index.

Test Plan:
- Empty map, req with pos (320,240), size 16:
  - map_addr sequence is 149, 150, 149, 150 on cycles k+2..k+5.
  - done at k+7 with coll_next = 0; busy is high from k+1 to k+7.
- Same query with map[150] = 4'h3: coll_next = 1 at done.
- Empty map, pos (10,240), size 16: x0 underflows, so coll_next = 1.
- Empty map, right-edge boundary:
  - pos (624,240): x1 = 639, so coll_next = 0.
  - pos (625,240): x1 = 640 is oob, so coll_next = 1.
- Second req asserted at k+3 during a check:
  - It is ignored; exactly one done pulse occurs at k+7.
  - A new req after return to IDLE is accepted normally.
- Reset asserted at k+4 mid-check:
  - Next cycle: busy = 0, done = 0, coll_next = 1.
  - No done pulse follows.

Source files
------------

// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared definitions for the tile-map collision checker: map and playfield
// geometry, tile/address types, the empty-tile code and the checker FSM
// state encoding.
// ---------------------------------------------------------------------------
package tile_pkg;

    localparam int MAP_W      = 20;   // tile-map width in tiles
    localparam int MAP_H      = 15;   // tile-map height in tiles
    localparam int TILE_SHIFT = 5;    // log2 of tile size (32 px tiles)
    localparam int SCREEN_W   = MAP_W << TILE_SHIFT;  // 640 px
    localparam int SCREEN_H   = MAP_H << TILE_SHIFT;  // 480 px
    localparam int ADDR_W     = 9;    // covers MAP_W*MAP_H = 300 entries
    localparam int TILE_W     = 4;    // tile-type width
    localparam int POS_W      = 10;   // pixel coordinate / half-size width
    localparam int COORD_W    = POS_W + 1;  // one extra bit exposes under/overflow

    typedef logic [TILE_W-1:0]  tile_t;
    typedef logic [ADDR_W-1:0]  map_addr_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam tile_t TILE_EMPTY = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/tile_collision_checker_if.sv
// ---------------------------------------------------------------------------
// tile_collision_checker_if
// Query handshake between the player-motion block (master) and the
// collision checker (slave).
//   req       : one-cycle query strobe (master -> slave)
//   pos_x/y   : candidate hitbox centre in pixels (master -> slave)
//   size      : hitbox half-size in pixels (master -> slave)
//   busy      : check in progress (slave -> master)
//   done      : one-cycle pulse when coll_next has been updated (slave -> master)
//   coll_next : 1 = candidate position collides; held between checks
// ---------------------------------------------------------------------------
interface tile_collision_checker_if;
    import tile_pkg::*;

    logic             req;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [POS_W-1:0] size;
    logic             busy;
    logic             done;
    logic             coll_next;

    modport master (
        output req, pos_x, pos_y, size,
        input  busy, done, coll_next
    );

    modport slave (
        input  req, pos_x, pos_y, size,
        output busy, done, coll_next
    );

endinterface

// File: rtl/tile_addr_calc.sv
// ---------------------------------------------------------------------------
// tile_addr_calc
// Combinational mapping of one hitbox corner to its tile-map address.
//   x, y : 11-bit corner coordinate; values >= 1024 are wrapped negatives
//   addr : row*MAP_W + col, or 0 when the corner is off the playfield
//   oob  : corner lies outside the playfield
// ---------------------------------------------------------------------------
module tile_addr_calc
    import tile_pkg::*;
(
    input  coord_t    x,
    input  coord_t    y,
    output map_addr_t addr,
    output logic      oob
);

    logic [COORD_W-TILE_SHIFT-1:0] col;
    logic [COORD_W-TILE_SHIFT-1:0] row;
    map_addr_t                     row_ext;

    assign col     = x[COORD_W-1:TILE_SHIFT];
    assign row     = y[COORD_W-1:TILE_SHIFT];
    assign row_ext = map_addr_t'(row);

    // A wrapped negative coordinate has its top bit set, so it is >= 1024
    // and the single unsigned compare catches underflow as well as overflow.
    assign oob = (x >= coord_t'(SCREEN_W)) || (y >= coord_t'(SCREEN_H));

    // row*20 as a shift-add; an oob corner parks the read on address 0.
    assign addr = oob ? '0
                      : (row_ext << 4) + (row_ext << 2) + map_addr_t'(col);

endmodule

// File: rtl/tile_collision_checker.sv
// ---------------------------------------------------------------------------
// tile_collision_checker
// Answers hitbox-vs-tile-map collision queries from the player-motion block.
// A query computes the four hitbox corners, reads each corner tile from the
// level map over a 1-cycle-latency port and reports whether any corner is
// solid or off the playfield. Fixed 7-cycle latency from req to done.
//   Clk      : system clock
//   Reset    : synchronous, active-high reset
//   bus      : query handshake (slave side)
//   map_addr : tile-map read address (0 whenever not reading)
//   map_data : tile type, valid the cycle after map_addr
// ---------------------------------------------------------------------------
module tile_collision_checker
    import tile_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Reset,
    tile_collision_checker_if.slave  bus,
    output map_addr_t                map_addr,
    input  tile_t                    map_data
);

    state_t           state;
    logic [1:0]       idx;
    logic             acc;
    logic             coll_q;

    logic [POS_W-1:0] px;
    logic [POS_W-1:0] py;
    logic [POS_W-1:0] ps;
    coord_t           x0, x1, y0, y1;

    coord_t           cx, cy;
    map_addr_t        c_addr;
    logic             c_oob;
    logic             hit;

    // ------------------------------------------------------------------
    // Corner selection for the shared address calculator.
    // Order: (x0,y0), (x1,y0), (x0,y1), (x1,y1).
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns cx/cy and no latch is inferred.
        cx = x0;
        cy = y0;
        case (idx)
            2'd0: begin cx = x0; cy = y0; end
            2'd1: begin cx = x1; cy = y0; end
            2'd2: begin cx = x0; cy = y1; end
            2'd3: begin cx = x1; cy = y1; end
            default: begin cx = x0; cy = y0; end
        endcase
    end

    tile_addr_calc u_addr_calc (
        .x    (cx),
        .y    (cy),
        .addr (c_addr),
        .oob  (c_oob)
    );

    assign map_addr = (state == ST_READ) ? c_addr : '0;
    assign hit      = (map_data != TILE_EMPTY);

    // ------------------------------------------------------------------
    // Datapath registers: query latch and corner coordinates.
    // ------------------------------------------------------------------
    // NOTE: these only carry data qualified by the FSM, so they have no reset.
    always_ff @(posedge Clk) begin
        if (state == ST_IDLE && bus.req) begin
            px <= bus.pos_x;
            py <= bus.pos_y;
            ps <= bus.size;
        end
        if (state == ST_CALC) begin
            x0 <= {1'b0, px} - {1'b0, ps};
            x1 <= {1'b0, px} + {1'b0, ps} - coord_t'(1);
            y0 <= {1'b0, py} - {1'b0, ps};
            y1 <= {1'b0, py} + {1'b0, ps} - coord_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and collision accumulator.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            acc    <= 1'b0;
            coll_q <= 1'b1;  // block motion until a check has completed
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc   <= 1'b0;
                    idx   <= '0;
                    state <= ST_READ;
                end
                ST_READ: begin
                    // This corner's oob flag now; map_data belongs to the
                    // previous index, so nothing to fold in on index 0.
                    acc <= acc | c_oob | ((idx != 2'd0) && hit);
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Final corner's data arrives here; loading the result on
                    // this edge makes coll_next valid during the done cycle.
                    acc    <= acc | hit;
                    coll_q <= acc | hit;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.coll_next = coll_q;

endmodule
